pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
Parametrised next-generation pipeline controller for the 5-stage MIPS core. It decodes an extended ISA in D and generates branch/jump control there. It carries control bits through per-stage registers (E/M/W) with stall and flush, and owns a multi-cycle multiplier sequencer that raises a D-stage interlock request for the hazard unit.

Parameters:
ALU_CTL_W, 4, width of ALUCtlE; must be at least 4.
MUL_LAT, 4, multiplier busy cycles after start; range 1..15.
HAS_MUL, 1, 0 makes mult/mflo decode as illegal and ties all Mul* outputs to 0.

Ports:
CLK  in  1  clock, rising edge
ResetN  in  1  asynchronous active-low reset
OpD  in  6  opcode in D
FunctD  in  6  funct in D
EqualD  in  1  register compare result in D
StallE  in  1  hold E control register
FlushE  in  1  clear E control register (bubble)
FlushM  in  1  clear M control register
BranchD, JumpD, JumpRegD, ExtOpD, PCSrcD  out  1  D-stage control
IllegalD  out  1  unsupported opcode/funct in D
MulStallD  out  1  interlock request: mult/mflo in D while multiplier busy
ALUSrcE  out  1  immediate operand select
RegDstE  out  2  0=rt, 1=rd, 2=r31 (jal)
LinkE  out  1  write PC+8 (jal)
ALUCtlE  out  ALU_CTL_W  ALU operation
MemToRegE, MemToRegM, MemToRegW  out  1  load result select per stage
MemWriteM  out  1  store enable
RegWriteE, RegWriteM, RegWriteW  out  1  register write per stage
MulStartE  out  1  one-cycle multiplier start pulse
MulBusyE  out  1  multiplier sequencer busy
HiLoSelW  out  1  writeback from LO (mflo)

Behaviour:
- Decode is combinational in D.
- R-type (Op 000000), funct mapping:
  - add 100000 -> ADD
  - sub 100010 -> SUB
  - and 100100 -> AND
  - or 100101 -> OR
  - nor 100111 -> NOR
  - slt 101010 -> SLT
  - sll 000000 -> SLL
  - jr 001000 -> JumpRegD=1, no RegWrite
  - mult 011000 -> Mul, no RegWrite
  - mflo 010010 -> RegWrite, HiLoSel
- I/J-type opcodes:
  - lw 100011, sw 101011, addi 001000 -> ADD
  - andi 001100, ori 001101 -> ExtOpD=0 (zero-extend)
  - slti 001010 -> SLT
  - lui 001111 -> LUI
  - beq 000100, bne 000101 -> Branch, SUB
  - j 000010
  - jal 000011 -> Jump, RegDst=2, Link, RegWrite
- ALU codes: AND=0, OR=1, ADD=2, NOR=3, SLL=4, LUI=5, SUB=6, SLT=7, PASS=8.
- Any other Op/funct: all control zero (NOP), IllegalD=1.
- PCSrcD = BranchD & (EqualD XOR bne).
- E register: FlushE has priority over StallE; on flush all E fields are 0. StallE holds E; otherwise E loads D control.
- M register: FlushM zeros it; otherwise loads E. Not affected by StallE; the hazard unit guarantees a bubble while E is held.
- W register loads M unconditionally.
- Reset (ResetN=0, asynchronous): every E/M/W field = 0, sequencer IDLE, started flag = 0. All registered outputs read 0 during and immediately after reset.
- Multiplier sequencer states:
  - IDLE -> BUSY when E holds a valid mult and the started flag = 0. MulStartE=1 for exactly that cycle, counter loads MUL_LAT-1, started flag set.
  - BUSY: counter decrements each cycle; BUSY -> IDLE when counter = 0.
  - MUL_LAT=1: BUSY lasts one cycle.
- MulBusyE = (state == BUSY).
- Started flag clears whenever E loads new contents or is flushed. A mult held by StallE therefore starts exactly once.
- MulStallD = (mult or mflo in D) & (MulBusyE | MulStartE).
- Flush of E in the MulStartE cycle does not abort the running multiply; the sequencer completes.
- Reset mid-BUSY aborts to IDLE immediately.

Decomposition:
- Package pipe_ctrl_pkg:
  - opcode and funct localparams
  - ALU code constants
  - RegDst encodings
  - control bundle struct: MemToReg, MemWrite, ALUSrc, RegDst, RegWrite, Link, ALUCtl, Mul, HiLoSel
- One sub-module pipe_ctrl_dec: combinational decoder producing the bundle, Branch/Jump/JumpReg/ExtOp/Illegal/bne.
- Stage registers and sequencer stay in the top module.

Test Plan:
- ResetN low mid-stream with lw in E/M/W -> all E/M/W outputs 0 asynchronously; after release, add issued -> RegWriteW=1 three cycles later, ALUCtl=2 seen in E.
- jal in D -> JumpD=1; next cycle RegDstE=2, LinkE=1, RegWriteE=1.
- bne with EqualD=0 -> PCSrcD=1; beq with EqualD=0 -> PCSrcD=0.
- mult, MUL_LAT=4 -> MulStartE one pulse, MulBusyE high 4 cycles. mflo in D during busy -> MulStallD=1 until busy drops.
- mult held by StallE=1 for 3 cycles -> exactly one MulStartE. FlushE and StallE together -> E zeroed.
- Op=111111 -> IllegalD=1, no RegWrite/MemWrite propagates. HAS_MUL=0: mult -> IllegalD=1, MulStartE never asserted.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the per-stage control bundle for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned ALU_W    = 4;
    localparam int unsigned REGDST_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
    localparam logic [OP_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
    localparam logic [OP_W-1:0] FN_JR   = 6'b001000;
    localparam logic [OP_W-1:0] FN_MULT = 6'b011000;
    localparam logic [OP_W-1:0] FN_MFLO = 6'b010010;

    localparam logic [ALU_W-1:0] ALU_AND  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd1;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_LUI  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_PASS = 4'd8;

    localparam logic [REGDST_W-1:0] REGDST_RT = 2'd0;
    localparam logic [REGDST_W-1:0] REGDST_RD = 2'd1;
    localparam logic [REGDST_W-1:0] REGDST_RA = 2'd2;

    typedef struct packed {
        logic                memToReg;
        logic                memWrite;
        logic                aluSrc;
        logic [REGDST_W-1:0] regDst;
        logic                regWrite;
        logic                link;
        logic [ALU_W-1:0]    aluCtl;
        logic                mul;
        logic                hiLoSel;
    } ctrlBundle_t;

endpackage

// File: rtl/pipe_ctrl_dec.sv
// D-stage decoder: opcode/funct to control bundle plus branch/jump controls.
module pipe_ctrl_dec
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned HAS_MUL = 1
) (
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    output ctrlBundle_t     ctrl,
    output logic            branch,
    output logic            jump,
    output logic            jumpReg,
    output logic            extOp,
    output logic            illegal,
    output logic            isBne
);

    always_comb begin
        ctrl    = '0;
        branch  = 1'b0;
        jump    = 1'b0;
        jumpReg = 1'b0;
        extOp   = 1'b0;
        illegal = 1'b0;
        isBne   = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.regDst   = REGDST_RD;
                ctrl.regWrite = 1'b1;
                case (funct)
                    FN_ADD: ctrl.aluCtl = ALU_ADD;
                    FN_SUB: ctrl.aluCtl = ALU_SUB;
                    FN_AND: ctrl.aluCtl = ALU_AND;
                    FN_OR:  ctrl.aluCtl = ALU_OR;
                    FN_NOR: ctrl.aluCtl = ALU_NOR;
                    FN_SLT: ctrl.aluCtl = ALU_SLT;
                    FN_SLL: ctrl.aluCtl = ALU_SLL;
                    FN_JR: begin
                        jumpReg       = 1'b1;
                        ctrl.regWrite = 1'b0;
                        ctrl.regDst   = REGDST_RT;
                    end
                    FN_MULT: begin
                        if (HAS_MUL != 0) begin
                            ctrl.mul      = 1'b1;
                            ctrl.regWrite = 1'b0;
                            ctrl.regDst   = REGDST_RT;
                            ctrl.aluCtl   = ALU_PASS;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    FN_MFLO: begin
                        if (HAS_MUL != 0) begin
                            ctrl.hiLoSel = 1'b1;
                            ctrl.aluCtl  = ALU_PASS;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.memToReg = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluCtl   = ALU_ADD;
                extOp         = 1'b1;
            end
            OP_SW: begin
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.aluCtl   = ALU_ADD;
                extOp         = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluCtl   = (op == OP_ADDI) ? ALU_ADD : ALU_SLT;
                extOp         = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluCtl   = (op == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_LUI: begin
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluCtl   = ALU_LUI;
                extOp         = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                branch      = 1'b1;
                isBne       = (op == OP_BNE);
                ctrl.aluCtl = ALU_SUB;
                extOp       = 1'b1;
            end
            OP_J: jump = 1'b1;
            OP_JAL: begin
                jump          = 1'b1;
                ctrl.regDst   = REGDST_RA;
                ctrl.link     = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // An unsupported encoding must behave as a pure bubble.
        if (illegal) begin
            ctrl    = '0;
            branch  = 1'b0;
            jump    = 1'b0;
            jumpReg = 1'b0;
            extOp   = 1'b0;
            isBne   = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline controller: D-stage decode, E/M/W control registers and the
// multi-cycle multiplier sequencer with its D-stage interlock request.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTL_W = 4,
    parameter int unsigned MUL_LAT   = 4,
    parameter int unsigned HAS_MUL   = 1
) (
    input  logic                 CLK,
    input  logic                 ResetN,
    input  logic [5:0]           OpD,
    input  logic [5:0]           FunctD,
    input  logic                 EqualD,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 FlushM,
    output logic                 BranchD,
    output logic                 JumpD,
    output logic                 JumpRegD,
    output logic                 ExtOpD,
    output logic                 PCSrcD,
    output logic                 IllegalD,
    output logic                 MulStallD,
    output logic                 ALUSrcE,
    output logic [1:0]           RegDstE,
    output logic                 LinkE,
    output logic [ALU_CTL_W-1:0] ALUCtlE,
    output logic                 MemToRegE,
    output logic                 MemToRegM,
    output logic                 MemToRegW,
    output logic                 MemWriteM,
    output logic                 RegWriteE,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic                 MulStartE,
    output logic                 MulBusyE,
    output logic                 HiLoSelW
);

    localparam int unsigned CNT_W = 4;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    ctrlBundle_t      ctrlD, ctrlE;
    logic             bneD;
    logic             memToRegM, memWriteM, regWriteM, hiLoSelM;
    logic             memToRegW, regWriteW, hiLoSelW;
    logic [0:0]       state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             started, startedNext, mulStart;

    pipe_ctrl_dec #(.HAS_MUL(HAS_MUL)) uDec (
        .op      (OpD),
        .funct   (FunctD),
        .ctrl    (ctrlD),
        .branch  (BranchD),
        .jump    (JumpD),
        .jumpReg (JumpRegD),
        .extOp   (ExtOpD),
        .illegal (IllegalD),
        .isBne   (bneD)
    );

    assign PCSrcD = BranchD & (EqualD ^ bneD);

    // E control register: flush wins over stall.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN)      ctrlE <= '0;
        else if (FlushE)  ctrlE <= '0;
        else if (!StallE) ctrlE <= ctrlD;
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            {memToRegM, memWriteM, regWriteM, hiLoSelM} <= '0;
        end else if (FlushM) begin
            {memToRegM, memWriteM, regWriteM, hiLoSelM} <= '0;
        end else begin
            {memToRegM, memWriteM, regWriteM, hiLoSelM} <=
                {ctrlE.memToReg, ctrlE.memWrite, ctrlE.regWrite, ctrlE.hiLoSel};
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) {memToRegW, regWriteW, hiLoSelW} <= '0;
        else         {memToRegW, regWriteW, hiLoSelW} <= {memToRegM, regWriteM, hiLoSelM};
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            started <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            started <= startedNext;
        end
    end

    // Started flag keeps a mult held in E by a stall from launching twice.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        startedNext = started;
        mulStart    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrlE.mul && !started) begin
                    mulStart    = 1'b1;
                    stateNext   = ST_BUSY;
                    cntNext     = CNT_W'(MUL_LAT - 1);
                    startedNext = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt == '0) stateNext = ST_IDLE;
                else           cntNext   = cnt - CNT_W'(1);
            end
            default: stateNext = ST_IDLE;
        endcase
        if (FlushE || !StallE) startedNext = 1'b0;
    end

    assign MulStartE = (HAS_MUL != 0) && mulStart;
    assign MulBusyE  = (HAS_MUL != 0) && (state == ST_BUSY);
    assign MulStallD = (HAS_MUL != 0) && (ctrlD.mul || ctrlD.hiLoSel) && (MulBusyE || MulStartE);

    assign ALUSrcE   = ctrlE.aluSrc;
    assign RegDstE   = ctrlE.regDst;
    assign LinkE     = ctrlE.link;
    assign ALUCtlE   = ALU_CTL_W'(ctrlE.aluCtl);
    assign MemToRegE = ctrlE.memToReg;
    assign RegWriteE = ctrlE.regWrite;
    assign MemToRegM = memToRegM;
    assign MemWriteM = memWriteM;
    assign RegWriteM = regWriteM;
    assign MemToRegW = memToRegW;
    assign RegWriteW = regWriteW;
    assign HiLoSelW  = hiLoSelW;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: default build plus no-multiplier and single-cycle-multiplier builds.
module tb_pipe_ctrl_unit;

    logic       CLK, ResetN, EqualD, StallE, FlushE, FlushM;
    logic [5:0] OpD, FunctD;

    logic BranchD, JumpD, JumpRegD, ExtOpD, PCSrcD, IllegalD, MulStallD, ALUSrcE, LinkE;
    logic MemToRegE, MemToRegM, MemToRegW, MemWriteM, RegWriteE, RegWriteM, RegWriteW;
    logic MulStartE, MulBusyE, HiLoSelW;
    logic [1:0] RegDstE;
    logic [3:0] ALUCtlE;

    logic nmBranchD, nmJumpD, nmJumpRegD, nmExtOpD, nmPCSrcD, nmIllegalD, nmMulStallD, nmALUSrcE, nmLinkE;
    logic nmMemToRegE, nmMemToRegM, nmMemToRegW, nmMemWriteM, nmRegWriteE, nmRegWriteM, nmRegWriteW;
    logic nmMulStartE, nmMulBusyE, nmHiLoSelW;
    logic [1:0] nmRegDstE;
    logic [3:0] nmALUCtlE;

    logic l1BranchD, l1JumpD, l1JumpRegD, l1ExtOpD, l1PCSrcD, l1IllegalD, l1MulStallD, l1ALUSrcE, l1LinkE;
    logic l1MemToRegE, l1MemToRegM, l1MemToRegW, l1MemWriteM, l1RegWriteE, l1RegWriteM, l1RegWriteW;
    logic l1MulStartE, l1MulBusyE, l1HiLoSelW;
    logic [1:0] l1RegDstE;
    logic [3:0] l1ALUCtlE;

    int nTests = 0;
    int nFail  = 0;

    localparam logic [5:0] BUB = 6'b111111;

    // {op, funct, ALUCtlE, RegWriteE, ALUSrcE, RegDstE}
    localparam logic [19:0] DEC_VEC [15] = '{
        {6'b000000, 6'b100000, 4'd2, 1'b1, 1'b0, 2'd1},
        {6'b000000, 6'b100010, 4'd6, 1'b1, 1'b0, 2'd1},
        {6'b000000, 6'b100100, 4'd0, 1'b1, 1'b0, 2'd1},
        {6'b000000, 6'b100101, 4'd1, 1'b1, 1'b0, 2'd1},
        {6'b000000, 6'b100111, 4'd3, 1'b1, 1'b0, 2'd1},
        {6'b000000, 6'b101010, 4'd7, 1'b1, 1'b0, 2'd1},
        {6'b000000, 6'b000000, 4'd4, 1'b1, 1'b0, 2'd1},
        {6'b001000, 6'b000000, 4'd2, 1'b1, 1'b1, 2'd0},
        {6'b001100, 6'b000000, 4'd0, 1'b1, 1'b1, 2'd0},
        {6'b001101, 6'b000000, 4'd1, 1'b1, 1'b1, 2'd0},
        {6'b001010, 6'b000000, 4'd7, 1'b1, 1'b1, 2'd0},
        {6'b001111, 6'b000000, 4'd5, 1'b1, 1'b1, 2'd0},
        {6'b100011, 6'b000000, 4'd2, 1'b1, 1'b1, 2'd0},
        {6'b101011, 6'b000000, 4'd2, 1'b0, 1'b1, 2'd0},
        {6'b000101, 6'b000000, 4'd6, 1'b0, 1'b0, 2'd0}
    };

    pipe_ctrl_unit dut (
        .CLK(CLK), .ResetN(ResetN), .OpD(OpD), .FunctD(FunctD), .EqualD(EqualD),
        .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM),
        .BranchD(BranchD), .JumpD(JumpD), .JumpRegD(JumpRegD), .ExtOpD(ExtOpD), .PCSrcD(PCSrcD),
        .IllegalD(IllegalD), .MulStallD(MulStallD), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
        .LinkE(LinkE), .ALUCtlE(ALUCtlE), .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
        .MemToRegW(MemToRegW), .MemWriteM(MemWriteM), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MulStartE(MulStartE), .MulBusyE(MulBusyE), .HiLoSelW(HiLoSelW)
    );

    pipe_ctrl_unit #(.HAS_MUL(0)) dutNoMul (
        .CLK(CLK), .ResetN(ResetN), .OpD(OpD), .FunctD(FunctD), .EqualD(EqualD),
        .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM),
        .BranchD(nmBranchD), .JumpD(nmJumpD), .JumpRegD(nmJumpRegD), .ExtOpD(nmExtOpD), .PCSrcD(nmPCSrcD),
        .IllegalD(nmIllegalD), .MulStallD(nmMulStallD), .ALUSrcE(nmALUSrcE), .RegDstE(nmRegDstE),
        .LinkE(nmLinkE), .ALUCtlE(nmALUCtlE), .MemToRegE(nmMemToRegE), .MemToRegM(nmMemToRegM),
        .MemToRegW(nmMemToRegW), .MemWriteM(nmMemWriteM), .RegWriteE(nmRegWriteE), .RegWriteM(nmRegWriteM),
        .RegWriteW(nmRegWriteW), .MulStartE(nmMulStartE), .MulBusyE(nmMulBusyE), .HiLoSelW(nmHiLoSelW)
    );

    pipe_ctrl_unit #(.MUL_LAT(1)) dutLat1 (
        .CLK(CLK), .ResetN(ResetN), .OpD(OpD), .FunctD(FunctD), .EqualD(EqualD),
        .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM),
        .BranchD(l1BranchD), .JumpD(l1JumpD), .JumpRegD(l1JumpRegD), .ExtOpD(l1ExtOpD), .PCSrcD(l1PCSrcD),
        .IllegalD(l1IllegalD), .MulStallD(l1MulStallD), .ALUSrcE(l1ALUSrcE), .RegDstE(l1RegDstE),
        .LinkE(l1LinkE), .ALUCtlE(l1ALUCtlE), .MemToRegE(l1MemToRegE), .MemToRegM(l1MemToRegM),
        .MemToRegW(l1MemToRegW), .MemWriteM(l1MemWriteM), .RegWriteE(l1RegWriteE), .RegWriteM(l1RegWriteM),
        .RegWriteW(l1RegWriteW), .MulStartE(l1MulStartE), .MulBusyE(l1MulBusyE), .HiLoSelW(l1HiLoSelW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn);
        OpD    = op;
        FunctD = fn;
    endtask

    task automatic test_reset;
        logic [13:0] outs;
        ResetN = 1'b0; EqualD = 1'b0; StallE = 1'b0; FlushE = 1'b0; FlushM = 1'b0;
        drive(6'b100011, 6'd0);
        repeat (2) @(posedge CLK);
        #1;
        outs = {RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, MemToRegW, MemWriteM,
                ALUSrcE, LinkE, MulStartE, MulBusyE, HiLoSelW, RegDstE != 2'd0, ALUCtlE != 4'd0};
        nTests++;
        if (outs !== 14'd0) begin nFail++; $display("FAIL reset_outs: got %b expected all zero", outs); end
        ResetN = 1'b1;
    endtask

    task automatic test_reset_midstream;
        drive(6'b100011, 6'd0);
        repeat (3) tick();
        nTests++;
        if ({MemToRegE, MemToRegM, MemToRegW, RegWriteW} !== 4'b1111) begin
            nFail++; $display("FAIL lw_fill: got %b expected 1111", {MemToRegE, MemToRegM, MemToRegW, RegWriteW});
        end
        #1 ResetN = 1'b0;
        #1;
        nTests++;
        if ({MemToRegE, MemToRegM, MemToRegW, RegWriteE, RegWriteM, RegWriteW, ALUSrcE} !== 7'd0) begin
            nFail++; $display("FAIL async_reset: got %b expected 0000000",
                              {MemToRegE, MemToRegM, MemToRegW, RegWriteE, RegWriteM, RegWriteW, ALUSrcE});
        end
        drive(6'b000000, 6'b100000);
        #1 ResetN = 1'b1;
        tick();
        nTests++;
        if ({ALUCtlE, RegWriteE} !== {4'd2, 1'b1}) begin
            nFail++; $display("FAIL add_E: got alu=%0d rw=%b expected alu=2 rw=1", ALUCtlE, RegWriteE);
        end
        drive(BUB, 6'd0);
        tick();
        tick();
        nTests++;
        if ({RegWriteE, RegWriteM, RegWriteW} !== 3'b001) begin
            nFail++; $display("FAIL add_W: got %b expected 001", {RegWriteE, RegWriteM, RegWriteW});
        end
    endtask

    task automatic test_jump;
        drive(6'b000011, 6'd0);
        #1;
        nTests++;
        if ({JumpD, BranchD, JumpRegD, IllegalD} !== 4'b1000) begin
            nFail++; $display("FAIL jal_D: got %b expected 1000", {JumpD, BranchD, JumpRegD, IllegalD});
        end
        tick();
        nTests++;
        if ({RegDstE, LinkE, RegWriteE} !== 4'b1011) begin
            nFail++; $display("FAIL jal_E: got %b expected 1011", {RegDstE, LinkE, RegWriteE});
        end
        drive(6'b000000, 6'b001000);
        #1;
        nTests++;
        if ({JumpD, JumpRegD, IllegalD} !== 3'b010) begin
            nFail++; $display("FAIL jr_D: got %b expected 010", {JumpD, JumpRegD, IllegalD});
        end
        tick();
        nTests++;
        if (RegWriteE !== 1'b0) begin nFail++; $display("FAIL jr_E: got rw=%b expected 0", RegWriteE); end
        drive(BUB, 6'd0);
    endtask

    task automatic test_branch;
        drive(6'b000101, 6'd0); EqualD = 1'b0; #1;
        nTests++;
        if ({BranchD, PCSrcD} !== 2'b11) begin nFail++; $display("FAIL bne_ne: got %b expected 11", {BranchD, PCSrcD}); end
        EqualD = 1'b1; #1;
        nTests++;
        if (PCSrcD !== 1'b0) begin nFail++; $display("FAIL bne_eq: got %b expected 0", PCSrcD); end
        drive(6'b000100, 6'd0); EqualD = 1'b0; #1;
        nTests++;
        if (PCSrcD !== 1'b0) begin nFail++; $display("FAIL beq_ne: got %b expected 0", PCSrcD); end
        EqualD = 1'b1; #1;
        nTests++;
        if (PCSrcD !== 1'b1) begin nFail++; $display("FAIL beq_eq: got %b expected 1", PCSrcD); end
        drive(BUB, 6'd0); #1;
        nTests++;
        if ({BranchD, PCSrcD} !== 2'b00) begin nFail++; $display("FAIL bub_eq: got %b expected 00", {BranchD, PCSrcD}); end
        EqualD = 1'b0;
    endtask

    task automatic test_decode;
        logic [19:0] v;
        logic [7:0]  got;
        for (int i = 0; i < 15; i++) begin
            v = DEC_VEC[i];
            drive(v[19:14], v[13:8]);
            tick();
            got = {ALUCtlE, RegWriteE, ALUSrcE, RegDstE};
            nTests++;
            if (got !== v[7:0]) begin
                nFail++; $display("FAIL decode_%0d: got %b expected %b", i, got, v[7:0]);
            end
        end
        drive(6'b001000, 6'd0); #1;
        nTests++;
        if (ExtOpD !== 1'b1) begin nFail++; $display("FAIL ext_addi: got %b expected 1", ExtOpD); end
        drive(6'b001100, 6'd0); #1;
        nTests++;
        if (ExtOpD !== 1'b0) begin nFail++; $display("FAIL ext_andi: got %b expected 0", ExtOpD); end
        drive(6'b001101, 6'd0); #1;
        nTests++;
        if (ExtOpD !== 1'b0) begin nFail++; $display("FAIL ext_ori: got %b expected 0", ExtOpD); end
        drive(6'b101011, 6'd0);
        tick();
        drive(BUB, 6'd0);
        tick();
        nTests++;
        if (MemWriteM !== 1'b1) begin nFail++; $display("FAIL sw_M: got %b expected 1", MemWriteM); end
        drive(6'b101011, 6'd0);
        tick();
        drive(BUB, 6'd0);
        FlushM = 1'b1;
        tick();
        FlushM = 1'b0;
        nTests++;
        if (MemWriteM !== 1'b0) begin nFail++; $display("FAIL flushM: got %b expected 0", MemWriteM); end
        tick();
    endtask

    task automatic test_mult;
        drive(6'b000000, 6'b011000); #1;
        nTests++;
        if (MulStallD !== 1'b0) begin nFail++; $display("FAIL mult_idle_stall: got %b expected 0", MulStallD); end
        tick();
        drive(6'b000000, 6'b010010);
        FlushE = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            nTests++;
            if ({MulStartE, MulBusyE, MulStallD} !== {i == 0, i >= 1 && i <= 4, i <= 4}) begin
                nFail++; $display("FAIL mul_seq_%0d: got %b expected %b", i, {MulStartE, MulBusyE, MulStallD},
                                  {i == 0, i >= 1 && i <= 4, i <= 4});
            end
            nTests++;
            if ({l1MulStartE, l1MulBusyE} !== {i == 0, i == 1}) begin
                nFail++; $display("FAIL lat1_seq_%0d: got %b expected %b", i, {l1MulStartE, l1MulBusyE}, {i == 0, i == 1});
            end
            tick();
        end
        FlushE = 1'b0;
        tick();
        drive(BUB, 6'd0);
        tick();
        tick();
        nTests++;
        if ({HiLoSelW, RegWriteW} !== 2'b11) begin
            nFail++; $display("FAIL mflo_W: got %b expected 11", {HiLoSelW, RegWriteW});
        end
        tick();
    endtask

    task automatic test_stall_mult;
        int starts, busy, l1Starts;
        starts = 0; busy = 0; l1Starts = 0;
        drive(6'b000000, 6'b011000);
        tick();
        drive(BUB, 6'd0);
        StallE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            starts   += int'(MulStartE);
            busy     += int'(MulBusyE);
            l1Starts += int'(l1MulStartE);
            if (i == 6) StallE = 1'b0;
            tick();
        end
        nTests++;
        if (starts != 1 || busy != 4) begin
            nFail++; $display("FAIL stall_mult: got starts=%0d busy=%0d expected starts=1 busy=4", starts, busy);
        end
        nTests++;
        if (l1Starts != 1) begin nFail++; $display("FAIL stall_mult_lat1: got starts=%0d expected 1", l1Starts); end
        drive(6'b100011, 6'd0);
        tick();
        StallE = 1'b1; FlushE = 1'b1;
        tick();
        nTests++;
        if ({MemToRegE, RegWriteE, ALUSrcE, ALUCtlE} !== 7'd0) begin
            nFail++; $display("FAIL flush_stall_E: got %b expected 0000000", {MemToRegE, RegWriteE, ALUSrcE, ALUCtlE});
        end
        StallE = 1'b0; FlushE = 1'b0;
        drive(BUB, 6'd0);
        tick();
    endtask

    task automatic test_reset_busy;
        drive(6'b000000, 6'b011000);
        tick();
        drive(BUB, 6'd0);
        tick();
        nTests++;
        if (MulBusyE !== 1'b1) begin nFail++; $display("FAIL busy_pre_reset: got %b expected 1", MulBusyE); end
        #1 ResetN = 1'b0;
        #1;
        nTests++;
        if ({MulBusyE, MulStartE} !== 2'b00) begin
            nFail++; $display("FAIL busy_reset: got %b expected 00", {MulBusyE, MulStartE});
        end
        #1 ResetN = 1'b1;
        tick();
        nTests++;
        if ({MulBusyE, MulStartE} !== 2'b00) begin
            nFail++; $display("FAIL busy_post_reset: got %b expected 00", {MulBusyE, MulStartE});
        end
    endtask

    task automatic test_illegal;
        int nmStarts;
        nmStarts = 0;
        drive(6'b000000, 6'b100000);
        tick();
        drive(BUB, 6'd0); #1;
        nTests++;
        if (IllegalD !== 1'b1) begin nFail++; $display("FAIL illegal_op: got %b expected 1", IllegalD); end
        tick();
        nTests++;
        if (RegWriteE !== 1'b0) begin nFail++; $display("FAIL illegal_E: got rw=%b expected 0", RegWriteE); end
        tick();
        tick();
        nTests++;
        if ({RegWriteE, RegWriteM, RegWriteW, MemWriteM} !== 4'b0000) begin
            nFail++; $display("FAIL illegal_pipe: got %b expected 0000", {RegWriteE, RegWriteM, RegWriteW, MemWriteM});
        end
        drive(6'b000000, 6'b000001); #1;
        nTests++;
        if (IllegalD !== 1'b1) begin nFail++; $display("FAIL illegal_funct: got %b expected 1", IllegalD); end
        tick();
        nTests++;
        if ({RegWriteE, RegDstE} !== 3'b000) begin
            nFail++; $display("FAIL illegal_funct_E: got %b expected 000", {RegWriteE, RegDstE});
        end
        drive(6'b000000, 6'b011000); #1;
        nTests++;
        if ({nmIllegalD, IllegalD} !== 2'b10) begin
            nFail++; $display("FAIL nomul_mult: got %b expected 10", {nmIllegalD, IllegalD});
        end
        tick();
        drive(BUB, 6'd0);
        for (int i = 0; i < 6; i++) begin
            nmStarts += int'(nmMulStartE) + int'(nmMulBusyE);
            tick();
        end
        nTests++;
        if (nmStarts != 0) begin nFail++; $display("FAIL nomul_start: got %0d active cycles expected 0", nmStarts); end
        drive(6'b000000, 6'b010010); #1;
        nTests++;
        if ({nmIllegalD, nmMulStallD} !== 2'b10) begin
            nFail++; $display("FAIL nomul_mflo: got %b expected 10", {nmIllegalD, nmMulStallD});
        end
        drive(BUB, 6'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_midstream();
        test_jump();
        test_branch();
        test_decode();
        test_mult();
        test_stall_mult();
        test_reset_busy();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
